axis_stream_checker: RTL and testbench

- Passive, parametrised AXI4-Stream protocol and content checker. It taps any AXIS link in the chip (e.g. between the stream master and slave) without driving it.
- Checks handshake stability, packet length, a per-channel byte-0 sequence number, and TDEST consistency.
- Reports sticky error flags, an interrupt, and packet/beat counters for bench and on-chip self-check.
- Generalises the fixed single-channel 64-byte stream to any data width and multiple TDEST channels.

---
 rtl/axis_stream_checker.sv | 165 ++++++++++++++++
 tb/tb_axis_stream_checker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stream_checker.sv
// Passive AXI4-Stream protocol/content checker: handshake stability, length, per-channel sequence,
// TDEST consistency. Optional stall timeout enabled by defining AXIS_CHK_TIMEOUT_EN.
module axis_stream_checker #(
    parameter int unsigned DATA_W      = 512,
    parameter int unsigned DEST_W      = 2,
    parameter int unsigned LEN_W       = 9,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              s_tvalid,
    input  logic              s_tready,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tlast,
    input  logic [DEST_W-1:0] s_tdest,
    input  logic [LEN_W-1:0]  exp_len,
    input  logic              clr_err,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic [4:0]        err_flags,
    output logic              err_irq
);

    localparam int unsigned NUM_CH = 2 ** DEST_W;
    localparam logic [LEN_W:0] CUR_ONE = {{LEN_W{1'b0}}, 1'b1};

    typedef enum logic [0:0] {IDLE, IN_PKT} state_t;

    state_t              r_state;
    logic [LEN_W-1:0]    r_bidx;
    logic [DEST_W-1:0]   r_dest;
    logic                r_pend;
    logic [DATA_W-1:0]   r_hold_data;
    logic                r_hold_last;
    logic [DEST_W-1:0]   r_hold_dest;
    logic [7:0]          r_exp_seq [NUM_CH];
    logic [CNT_W-1:0]    r_pkt_cnt;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic [4:0]          r_err;
    logic                r_irq;

    logic                w_hs;
    logic                w_stall;
    logic [LEN_W:0]      w_cur;
    logic                w_stable_err;
    logic                w_len_err;
    logic                w_seq_err;
    logic                w_dest_err;
    logic                w_timeout;
    logic [4:0]          w_new_err;
    logic [4:0]          w_err_d;

    assign w_hs    = s_tvalid & s_tready;
    assign w_stall = s_tvalid & ~s_tready;

    // Beat number of the current handshake, one bit wider so a saturated index never matches
    assign w_cur = (r_state == IDLE) ? CUR_ONE : ({1'b0, r_bidx} + CUR_ONE);

    assign w_stable_err = r_pend & (~s_tvalid | (s_tdata != r_hold_data) |
                                    (s_tlast != r_hold_last) | (s_tdest != r_hold_dest));
    assign w_len_err    = (|exp_len) & w_hs &
                          (s_tlast ? (w_cur != {1'b0, exp_len}) : (w_cur == {1'b0, exp_len}));
    assign w_seq_err    = w_hs & (s_tdata[7:0] != r_exp_seq[s_tdest]);
    assign w_dest_err   = w_hs & (r_state == IN_PKT) & (s_tdest != r_dest);

    assign w_new_err = {w_timeout, w_dest_err, w_seq_err, w_len_err, w_stable_err};
    // A new error beats a simultaneous clear for its own bit
    assign w_err_d   = (clr_err ? 5'b00000 : r_err) | w_new_err;

`ifdef AXIS_CHK_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(TIMEOUT_CYC);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYC - 1);

    logic [STALL_W-1:0] r_stall;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_stall <= '0;
        end else if (!w_stall) begin
            r_stall <= '0;
        end else if (r_stall != STALL_MAX) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign w_timeout = w_stall & (r_stall == STALL_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_pend      <= 1'b0;
            r_hold_data <= '0;
            r_hold_last <= 1'b0;
            r_hold_dest <= '0;
        end else begin
            r_pend <= w_stall;
            if (w_stall) begin
                r_hold_data <= s_tdata;
                r_hold_last <= s_tlast;
                r_hold_dest <= s_tdest;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= IDLE;
            r_bidx  <= '0;
            r_dest  <= '0;
        end else if (w_hs) begin
            if (s_tlast) begin
                r_state <= IDLE;
                r_bidx  <= '0;
            end else if (r_state == IDLE) begin
                r_state <= IN_PKT;
                r_dest  <= s_tdest;
                r_bidx  <= {{(LEN_W-1){1'b0}}, 1'b1};
            end else begin
                r_dest <= s_tdest;
                if (r_bidx != '1) begin
                    r_bidx <= r_bidx + 1'b1;
                end
            end
        end
    end

    // On a mismatch the expected value resyncs to the observed byte, so both cases store data+1
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_exp_seq[i] <= 8'h00;
            end
        end else if (w_hs) begin
            r_exp_seq[s_tdest] <= s_tdata[7:0] + 8'd1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_pkt_cnt  <= '0;
            r_beat_cnt <= '0;
            r_err      <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_err <= w_err_d;
            r_irq <= |w_err_d;
            if (w_hs && (r_beat_cnt != '1)) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            if (w_hs && s_tlast && (r_pkt_cnt != '1)) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end
        end
    end

    assign pkt_cnt   = r_pkt_cnt;
    assign beat_cnt  = r_beat_cnt;
    assign err_flags = r_err;
    assign err_irq   = r_irq;

endmodule

// File: tb/tb_axis_stream_checker.sv
// Directed self-checking bench for axis_stream_checker; honours AXIS_CHK_TIMEOUT_EN for bit4.
module tb_axis_stream_checker;

    logic        aclk;
    logic        areset;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic [1:0]  s_tdest;
    logic [8:0]  exp_len;
    logic        clr_err;
    logic [31:0] pkt_cnt;
    logic [31:0] beat_cnt;
    logic [4:0]  err_flags;
    logic        err_irq;

    int n_vec = 0;
    int n_err = 0;

`ifdef AXIS_CHK_TIMEOUT_EN
    localparam logic [4:0] TO_BIT = 5'b10000;
`else
    localparam logic [4:0] TO_BIT = 5'b00000;
`endif

    axis_stream_checker #(
        .DATA_W      (32),
        .DEST_W      (2),
        .LEN_W       (9),
        .CNT_W       (32),
        .TIMEOUT_CYC (16)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tdata   (s_tdata),
        .s_tlast   (s_tlast),
        .s_tdest   (s_tdest),
        .exp_len   (exp_len),
        .clr_err   (clr_err),
        .pkt_cnt   (pkt_cnt),
        .beat_cnt  (beat_cnt),
        .err_flags (err_flags),
        .err_irq   (err_irq)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        areset   = 1'b1;
        s_tvalid = 1'b0;
        s_tready = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        s_tdest  = '0;
        exp_len  = '0;
        clr_err  = 1'b0;
        tick();
        areset = 1'b0;
        tick();
    endtask

    // One single-cycle handshake; link goes idle afterwards unless the next beat follows
    task automatic beat(input logic [7:0] b, input logic l, input logic [1:0] d);
        s_tvalid = 1'b1;
        s_tready = 1'b1;
        s_tdata  = {8'hC0, 8'h00, 8'h5A, b};
        s_tlast  = l;
        s_tdest  = d;
        tick();
        s_tvalid = 1'b0;
        s_tready = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        areset   = 1'b1;
        s_tvalid = 1'b0;
        s_tready = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        s_tdest  = '0;
        exp_len  = '0;
        clr_err  = 1'b0;
        tick();
        n_vec++; if (pkt_cnt !== 32'd0) begin n_err++; $display("FAIL reset_pkt got %0d want 0", pkt_cnt); end
        n_vec++; if (beat_cnt !== 32'd0) begin n_err++; $display("FAIL reset_beat got %0d want 0", beat_cnt); end
        n_vec++; if (err_flags !== 5'b0) begin n_err++; $display("FAIL reset_err got %b want 00000", err_flags); end
        n_vec++; if (err_irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", err_irq); end
        areset = 1'b0;
        tick();
    endtask

    task automatic test_normal();
        int k;
        int cyc;
        do_reset();
        exp_len = 9'd8;
        k = 0;
        cyc = 0;
        while (k < 8 && cyc < 100) begin
            s_tvalid = 1'b1;
            s_tready = (cyc % 8) >= 2;
            s_tdata  = {24'h00A500, 8'(k)};
            s_tlast  = (k == 7);
            s_tdest  = 2'd0;
            tick();
            if (s_tready) k++;
            cyc++;
        end
        s_tvalid = 1'b0;
        s_tready = 1'b0;
        s_tlast  = 1'b0;
        tick();
        n_vec++; if (k !== 8) begin n_err++; $display("FAIL normal_done got %0d beats want 8", k); end
        n_vec++; if (pkt_cnt !== 32'd1) begin n_err++; $display("FAIL normal_pkt got %0d want 1", pkt_cnt); end
        n_vec++; if (beat_cnt !== 32'd8) begin n_err++; $display("FAIL normal_beat got %0d want 8", beat_cnt); end
        n_vec++; if (err_flags !== 5'b0) begin n_err++; $display("FAIL normal_err got %b want 00000", err_flags); end
        n_vec++; if (err_irq !== 1'b0) begin n_err++; $display("FAIL normal_irq got %b want 0", err_irq); end
    endtask

    task automatic test_stable();
        do_reset();
        s_tvalid = 1'b1;
        s_tready = 1'b0;
        s_tdata  = 32'h0000_0003;
        tick();
        n_vec++; if (err_flags !== 5'b0) begin n_err++; $display("FAIL stable_hold got %b want 00000", err_flags); end
        s_tdata = 32'h0000_0004;
        tick();
        n_vec++; if (err_flags !== 5'b00001) begin n_err++; $display("FAIL stable_flag got %b want 00001", err_flags); end
        n_vec++; if (err_irq !== 1'b1) begin n_err++; $display("FAIL stable_irq got %b want 1", err_irq); end
        pulse_clr();
        n_vec++; if (err_flags !== 5'b0) begin n_err++; $display("FAIL stable_clr got %b want 00000", err_flags); end
        n_vec++; if (err_irq !== 1'b0) begin n_err++; $display("FAIL stable_clr_irq got %b want 0", err_irq); end
    endtask

    task automatic test_length();
        do_reset();
        exp_len = 9'd8;
        for (int i = 0; i < 5; i++) beat(8'(i), i == 4, 2'd0);
        n_vec++; if (err_flags !== 5'b00010) begin n_err++; $display("FAIL short_err got %b want 00010", err_flags); end
        n_vec++; if (pkt_cnt !== 32'd1) begin n_err++; $display("FAIL short_pkt got %0d want 1", pkt_cnt); end
        n_vec++; if (err_irq !== 1'b1) begin n_err++; $display("FAIL short_irq got %b want 1", err_irq); end
        pulse_clr();
        for (int i = 0; i < 7; i++) beat(8'(5 + i), 1'b0, 2'd0);
        n_vec++; if (err_flags !== 5'b0) begin n_err++; $display("FAIL long_pre got %b want 00000", err_flags); end
        beat(8'd12, 1'b0, 2'd0);
        n_vec++; if (err_flags !== 5'b00010) begin n_err++; $display("FAIL long_beat8 got %b want 00010", err_flags); end
        beat(8'd13, 1'b1, 2'd0);
        n_vec++; if (pkt_cnt !== 32'd2) begin n_err++; $display("FAIL long_pkt got %0d want 2", pkt_cnt); end
    endtask

    task automatic test_seq();
        do_reset();
        beat(8'd0, 1'b0, 2'd0);
        beat(8'd1, 1'b0, 2'd0);
        n_vec++; if (err_flags !== 5'b0) begin n_err++; $display("FAIL seq_ok got %b want 00000", err_flags); end
        beat(8'd3, 1'b0, 2'd0);
        n_vec++; if (err_flags !== 5'b00100) begin n_err++; $display("FAIL seq_gap got %b want 00100", err_flags); end
        pulse_clr();
        beat(8'd4, 1'b1, 2'd0);
        n_vec++; if (err_flags !== 5'b0) begin n_err++; $display("FAIL seq_resync got %b want 00000", err_flags); end
        n_vec++; if (beat_cnt !== 32'd4) begin n_err++; $display("FAIL seq_beat got %0d want 4", beat_cnt); end
    endtask

    task automatic test_channels();
        do_reset();
        exp_len = 9'd4;
        for (int i = 0; i < 4; i++) beat(8'(i), i == 3, 2'd0);
        for (int i = 0; i < 4; i++) beat(8'(i), i == 3, 2'd1);
        for (int i = 0; i < 4; i++) beat(8'(4 + i), i == 3, 2'd0);
        n_vec++; if (err_flags !== 5'b0) begin n_err++; $display("FAIL chan_clean got %b want 00000", err_flags); end
        n_vec++; if (pkt_cnt !== 32'd3) begin n_err++; $display("FAIL chan_pkt got %0d want 3", pkt_cnt); end
        n_vec++; if (beat_cnt !== 32'd12) begin n_err++; $display("FAIL chan_beat got %0d want 12", beat_cnt); end
        exp_len = 9'd0;
        beat(8'd8, 1'b0, 2'd0);
        beat(8'd4, 1'b0, 2'd1);
        n_vec++; if (err_flags !== 5'b01000) begin n_err++; $display("FAIL chan_dest got %b want 01000", err_flags); end
    endtask

    task automatic test_reset_mid_and_timeout();
        do_reset();
        for (int i = 0; i < 3; i++) beat(8'(i), 1'b0, 2'd0);
        areset = 1'b1;
        #1;
        n_vec++; if (pkt_cnt !== 32'd0) begin n_err++; $display("FAIL mid_rst_pkt got %0d want 0", pkt_cnt); end
        n_vec++; if (beat_cnt !== 32'd0) begin n_err++; $display("FAIL mid_rst_beat got %0d want 0", beat_cnt); end
        n_vec++; if (err_flags !== 5'b0) begin n_err++; $display("FAIL mid_rst_err got %b want 00000", err_flags); end
        areset = 1'b0;
        beat(8'd0, 1'b0, 2'd0);
        beat(8'd1, 1'b1, 2'd0);
        n_vec++; if (err_flags !== 5'b0) begin n_err++; $display("FAIL mid_rst_seq got %b want 00000", err_flags); end
        n_vec++; if (pkt_cnt !== 32'd1) begin n_err++; $display("FAIL mid_rst_pkt2 got %0d want 1", pkt_cnt); end

        do_reset();
        s_tvalid = 1'b1;
        s_tready = 1'b0;
        s_tdata  = 32'h0000_0055;
        for (int i = 0; i < 15; i++) tick();
        n_vec++; if (err_flags !== 5'b0) begin n_err++; $display("FAIL stall15 got %b want 00000", err_flags); end
        tick();
        n_vec++; if (err_flags !== TO_BIT) begin n_err++; $display("FAIL stall16 got %b want %b", err_flags, TO_BIT); end
        n_vec++; if (err_irq !== (|TO_BIT)) begin n_err++; $display("FAIL stall16_irq got %b want %b", err_irq, |TO_BIT); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_stable();
        test_length();
        test_seq();
        test_channels();
        test_reset_mid_and_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
